// File: rtl/dense_output_layer_pkg.sv
// Shared sizes, FSM state encodings and width helpers for the dense output layer
// and the argmax stage that consumes its scores.
package dense_output_layer_pkg;

  localparam int DEF_IN_SIZE    = 32;
  localparam int DEF_OUT_SIZE   = 10;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MAC  = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } layer_state_t;

  // Index width that never collapses to zero bits for single-entry tables.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Headroom of clog2(n) bits above a full product keeps an n-term sum exact.
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + addr_width(n);
  endfunction

endpackage

// File: rtl/dense_weight_rom.sv
// Weight and bias tables with registered reads; contents are loaded through the
// write port after power-up, weights at 0..IN*OUT-1, biases directly after them.
module dense_weight_rom
  import dense_output_layer_pkg::*;
#(
  parameter int IN_SIZE    = DEF_IN_SIZE,
  parameter int OUT_SIZE   = DEF_OUT_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                                          clk,
  input  logic                                          i_wr_en,
  input  logic [addr_width(IN_SIZE*OUT_SIZE+OUT_SIZE)-1:0] i_wr_addr,
  input  logic signed [DATA_WIDTH-1:0]                  i_wr_data,
  input  logic [addr_width(IN_SIZE*OUT_SIZE)-1:0]       i_w_addr,
  input  logic [addr_width(OUT_SIZE)-1:0]               i_b_addr,
  output logic signed [DATA_WIDTH-1:0]                  o_weight,
  output logic signed [DATA_WIDTH-1:0]                  o_bias
);

  localparam int WN      = IN_SIZE * OUT_SIZE;
  localparam int CFG_AW  = addr_width(WN + OUT_SIZE);
  localparam int WGT_AW  = addr_width(WN);
  localparam int BIAS_AW = addr_width(OUT_SIZE);
  localparam logic [CFG_AW-1:0] BIAS_BASE = CFG_AW'(WN);

  logic signed [DATA_WIDTH-1:0] r_weight_mem [WN];
  logic signed [DATA_WIDTH-1:0] r_bias_mem   [OUT_SIZE];

  logic               w_wr_weight;
  logic               w_wr_bias;
  logic [BIAS_AW-1:0] w_bias_wa;

  assign w_wr_weight = i_wr_en && (i_wr_addr < BIAS_BASE);
  assign w_wr_bias   = i_wr_en && (i_wr_addr >= BIAS_BASE);
  assign w_bias_wa   = BIAS_AW'(i_wr_addr - BIAS_BASE);

  always_ff @(posedge clk) begin
    if (w_wr_weight) begin
      r_weight_mem[i_wr_addr[WGT_AW-1:0]] <= i_wr_data;
    end
    if (w_wr_bias) begin
      r_bias_mem[w_bias_wa] <= i_wr_data;
    end
    o_weight <= r_weight_mem[i_w_addr];
    o_bias   <= r_bias_mem[i_b_addr];
  end

endmodule

// File: rtl/dense_output_layer.sv
// Fully connected output layer: buffers one frame of activations, then emits one
// fixed-point score per neuron. DENSE_OUTPUT_SATURATE_EN clamps scores instead of wrapping.
module dense_output_layer
  import dense_output_layer_pkg::*;
#(
  parameter int IN_SIZE    = DEF_IN_SIZE,
  parameter int OUT_SIZE   = DEF_OUT_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          start_layer,
  input  logic                                          in_valid,
  input  logic signed [DATA_WIDTH-1:0]                  data_in,
  input  logic                                          i_cfg_we,
  input  logic [addr_width(IN_SIZE*OUT_SIZE+OUT_SIZE)-1:0] i_cfg_addr,
  input  logic signed [DATA_WIDTH-1:0]                  i_cfg_data,
  output logic                                          start_argmax,
  output logic                                          data_valid,
  output logic signed [DATA_WIDTH-1:0]                  class_out,
  output logic                                          finish_layer,
  output logic                                          busy
);

  localparam int DW      = DATA_WIDTH;
  localparam int ACC_W   = acc_width(DATA_WIDTH, IN_SIZE);
  localparam int CNT_W   = addr_width(IN_SIZE + 1);
  localparam int IDX_W   = addr_width(IN_SIZE);
  localparam int NEU_W   = addr_width(OUT_SIZE);
  localparam int WGT_AW  = addr_width(IN_SIZE * OUT_SIZE);
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(IN_SIZE);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [NEU_W-1:0] NEURON_LAST = NEU_W'(OUT_SIZE - 1);

  layer_state_t r_state;
  layer_state_t w_state_next;

  logic [CNT_W-1:0]            r_load_cnt;
  logic [CNT_W-1:0]            r_k;
  logic [NEU_W-1:0]            r_neuron;
  logic signed [ACC_W-1:0]     r_acc;
  logic signed [DW-1:0]        r_class_out;
  logic signed [DW-1:0]        r_buf [IN_SIZE];
  logic signed [DW-1:0]        r_buf_q;

  logic                        w_load_we;
  logic [IDX_W-1:0]            w_rd_idx;
  logic [WGT_AW-1:0]           w_w_addr;
  logic signed [DW-1:0]        w_weight;
  logic signed [DW-1:0]        w_bias;
  logic signed [2*DW-1:0]      w_buf_ext;
  logic signed [2*DW-1:0]      w_wgt_ext;
  logic signed [2*DW-1:0]      w_prod;
  logic signed [ACC_W-1:0]     w_prod_ext;
  logic signed [ACC_W-1:0]     w_bias_sh;
  logic signed [ACC_W-1:0]     w_acc_next;
  logic signed [DW-1:0]        w_reduced;

  dense_weight_rom #(
    .IN_SIZE   (IN_SIZE),
    .OUT_SIZE  (OUT_SIZE),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rom (
    .clk      (clk),
    .i_wr_en  (i_cfg_we),
    .i_wr_addr(i_cfg_addr),
    .i_wr_data(i_cfg_data),
    .i_w_addr (w_w_addr),
    .i_b_addr (r_neuron),
    .o_weight (w_weight),
    .o_bias   (w_bias)
  );

  always_comb begin
    w_state_next = r_state;
    start_argmax = 1'b0;
    data_valid   = 1'b0;
    finish_layer = 1'b0;
    busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (start_layer) begin
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (r_load_cnt == CNT_FULL) begin
          w_state_next = ST_MAC;
          start_argmax = 1'b1;
        end
      end
      ST_MAC: begin
        if (r_k == CNT_FULL) begin
          w_state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        data_valid   = 1'b1;
        w_state_next = (r_neuron == NEURON_LAST) ? ST_DONE : ST_MAC;
      end
      ST_DONE: begin
        finish_layer = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // MAC cycle k issues reads for term k; the term is summed one cycle later,
  // so cycle 0 only primes the pipeline and cycle 1 seeds the bias.
  assign w_load_we  = (r_state == ST_LOAD) && in_valid && (r_load_cnt < CNT_FULL);
  assign w_rd_idx   = (r_k < CNT_FULL) ? r_k[IDX_W-1:0] : '0;
  assign w_w_addr   = WGT_AW'(int'(r_neuron) * IN_SIZE + int'(w_rd_idx));
  assign w_buf_ext  = {{DW{r_buf_q[DW-1]}}, r_buf_q};
  assign w_wgt_ext  = {{DW{w_weight[DW-1]}}, w_weight};
  assign w_prod     = w_buf_ext * w_wgt_ext;
  assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
  assign w_bias_sh  = {{(ACC_W-DW){w_bias[DW-1]}}, w_bias} <<< FRAC_BITS;
  assign w_acc_next = ((r_k == CNT_ONE) ? w_bias_sh : r_acc) + w_prod_ext;

`ifdef DENSE_OUTPUT_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [ACC_W-1:0] w_shifted;
  assign w_shifted = w_acc_next >>> FRAC_BITS;

  always_comb begin
    w_reduced = w_shifted[DW-1:0];
    if (w_shifted > SAT_MAX) begin
      w_reduced = {1'b0, {(DW-1){1'b1}}};
    end else if (w_shifted < SAT_MIN) begin
      w_reduced = {1'b1, {(DW-1){1'b0}}};
    end
  end
`else
  assign w_reduced = DW'(w_acc_next >>> FRAC_BITS);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_load_cnt  <= '0;
      r_k         <= '0;
      r_neuron    <= '0;
      r_acc       <= '0;
      r_class_out <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (start_layer) begin
            r_load_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (w_load_we) begin
            r_load_cnt <= r_load_cnt + CNT_ONE;
          end
          if (r_load_cnt == CNT_FULL) begin
            r_neuron <= '0;
            r_k      <= '0;
          end
        end
        ST_MAC: begin
          r_k <= (r_k == CNT_FULL) ? '0 : r_k + CNT_ONE;
          if (r_k != '0) begin
            r_acc <= w_acc_next;
          end
          if (r_k == CNT_FULL) begin
            r_class_out <= w_reduced;
          end
        end
        ST_EMIT: begin
          r_neuron <= (r_neuron == NEURON_LAST) ? '0 : r_neuron + NEU_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Activation buffer is plain storage; a mid-frame reset leaves it as is.
  always_ff @(posedge clk) begin
    if (w_load_we) begin
      r_buf[r_load_cnt[IDX_W-1:0]] <= data_in;
    end
    r_buf_q <= r_buf[w_rd_idx];
  end

  assign class_out = r_class_out;

endmodule

// File: tb/tb_dense_output_layer.sv
// Directed bench for dense_output_layer (IN_SIZE=4, OUT_SIZE=3, Q8.8 operands).
module tb_dense_output_layer;
  import dense_output_layer_pkg::*;

  localparam int IN     = 4;
  localparam int OUT    = 3;
  localparam int DW     = 16;
  localparam int FB     = 8;
  localparam int CFG_AW = addr_width(IN * OUT + OUT);
  localparam int LAT    = IN + 2;
`ifdef DENSE_OUTPUT_SATURATE_EN
  localparam int S3_EXP = 32767;
`else
  localparam int S3_EXP = -1024;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start_layer = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] data_in = '0;
  logic                 i_cfg_we = 1'b0;
  logic [CFG_AW-1:0]    i_cfg_addr = '0;
  logic signed [DW-1:0] i_cfg_data = '0;
  logic                 start_argmax;
  logic                 data_valid;
  logic signed [DW-1:0] class_out;
  logic                 finish_layer;
  logic                 busy;

  dense_output_layer #(
    .IN_SIZE   (IN),
    .OUT_SIZE  (OUT),
    .DATA_WIDTH(DW),
    .FRAC_BITS (FB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_layer (start_layer),
    .in_valid    (in_valid),
    .data_in     (data_in),
    .i_cfg_we    (i_cfg_we),
    .i_cfg_addr  (i_cfg_addr),
    .i_cfg_data  (i_cfg_data),
    .start_argmax(start_argmax),
    .data_valid  (data_valid),
    .class_out   (class_out),
    .finish_layer(finish_layer),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int dv_val[$];
  int dv_cyc[$];
  int sa_cyc  = 0;
  int sa_cnt  = 0;
  int fin_cnt = 0;
  int inp[IN];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (start_argmax) begin
      sa_cyc = cyc;
      sa_cnt = sa_cnt + 1;
    end
    if (data_valid) begin
      dv_val.push_back(int'(class_out));
      dv_cyc.push_back(cyc);
      $display("[TB] t=%0t score %0d = %0d", $time, dv_val.size() - 1, class_out);
    end
    if (finish_layer) fin_cnt = fin_cnt + 1;
  end

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input int addr, input int val);
    @(negedge clk);
    i_cfg_we   = 1'b1;
    i_cfg_addr = CFG_AW'(addr);
    i_cfg_data = DW'(val);
    @(negedge clk);
    i_cfg_we   = 1'b0;
  endtask

  task automatic program_rom(input int w_all, input int w_row1, input int b1);
    for (int n = 0; n < OUT; n++) begin
      for (int k = 0; k < IN; k++) cfg_write(n * IN + k, (n == 1) ? w_row1 : w_all);
    end
    for (int n = 0; n < OUT; n++) cfg_write(IN * OUT + n, (n == 1) ? b1 : 0);
  endtask

  task automatic clear_mon();
    dv_val.delete();
    dv_cyc.delete();
    sa_cnt  = 0;
    fin_cnt = 0;
    sa_cyc  = 0;
  endtask

  task automatic run_frame(input bit gap, input int extra, input bit restart_mid);
    @(negedge clk);
    start_layer = 1'b1;
    @(negedge clk);
    start_layer = 1'b0;
    for (int i = 0; i < IN; i++) begin
      in_valid = 1'b1;
      data_in  = DW'(inp[i]);
      if (restart_mid && i == 2) start_layer = 1'b1;
      @(negedge clk);
      start_layer = 1'b0;
      if (gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    for (int e = 0; e < extra; e++) begin
      in_valid = 1'b1;
      data_in  = 16'sh7ABC;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_finish(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (fin_cnt > 0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_finish_seen"}, 32'(seen), 1);
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  task automatic check_frame(input string tag, input int e0, input int e1, input int e2);
    int exp_v[3];
    exp_v[0] = e0;
    exp_v[1] = e1;
    exp_v[2] = e2;
    chk({tag, "_count"}, dv_val.size(), OUT);
    for (int n = 0; n < OUT; n++) begin
      if (n < dv_val.size()) begin
        chk($sformatf("%s_score%0d", tag, n), dv_val[n], exp_v[n]);
        chk($sformatf("%s_lat%0d", tag, n), dv_cyc[n] - sa_cyc, (n + 1) * LAT);
      end
    end
    chk({tag, "_argmax_pulses"}, sa_cnt, 1);
    chk({tag, "_finish_pulses"}, fin_cnt, 1);
  endtask

  initial begin
    inp = '{256, 512, 768, 1024};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data_valid", 32'(data_valid), 0);
    chk("rst_class_out", class_out, 0);
    chk("rst_start_argmax", 32'(start_argmax), 0);
    chk("rst_finish", 32'(finish_layer), 0);
    reset_n = 1'b1;

    // Scenario 1: unit weights, zero bias -> 10.0 for every class
    program_rom(256, 256, 0);
    clear_mon();
    run_frame(1'b0, 0, 1'b0);
    wait_finish("s1");
    check_frame("s1", 2560, 2560, 2560);
    chk("s1_hold_class_out", class_out, 2560);
    chk("s1_hold_valid_low", 32'(data_valid), 0);

    // Scenario 2: negative row and bias pass straight through
    program_rom(256, -256, -256);
    clear_mon();
    run_frame(1'b0, 0, 1'b0);
    wait_finish("s2");
    check_frame("s2", 2560, -2816, 2560);

    // Scenario 3: full-scale operands exercise the reduction mode
    program_rom(32767, 32767, 0);
    inp = '{32767, 32767, 32767, 32767};
    clear_mon();
    run_frame(1'b0, 0, 1'b0);
    wait_finish("s3");
    check_frame("s3", S3_EXP, S3_EXP, S3_EXP);

    // Scenario 4: gapped input plus surplus words
    program_rom(256, 256, 0);
    inp = '{256, 512, 768, 1024};
    clear_mon();
    run_frame(1'b1, 2, 1'b0);
    wait_finish("s4");
    check_frame("s4", 2560, 2560, 2560);

    // Scenario 5: reset during neuron 1 accumulation
    clear_mon();
    run_frame(1'b0, 0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (dv_val.size() >= 1) break;
      @(negedge clk);
    end
    chk("s5_first_score_seen", dv_val.size(), 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("s5_rst_busy", 32'(busy), 0);
    chk("s5_rst_data_valid", 32'(data_valid), 0);
    chk("s5_rst_class_out", class_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("s5_no_more_scores", dv_val.size(), 1);
    chk("s5_no_finish", fin_cnt, 0);
    chk("s5_idle_busy", 32'(busy), 0);
    clear_mon();
    run_frame(1'b0, 0, 1'b0);
    wait_finish("s5b");
    check_frame("s5b", 2560, 2560, 2560);

    // Scenario 6: start_layer while busy (during LOAD and during MAC) is ignored
    clear_mon();
    run_frame(1'b0, 0, 1'b1);
    repeat (2) @(negedge clk);
    start_layer = 1'b1;
    @(negedge clk);
    start_layer = 1'b0;
    wait_finish("s6");
    check_frame("s6", 2560, 2560, 2560);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
